// File: rtl/cordic_vectoring_iter.sv
// Iterative vectoring-mode CORDIC returning atan(Y/X) as an IEEE-754 float.
// Defining CORDIC_MAG_EN adds the n=1 magnitude path (SCALE state plus gain multiplier).
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   S_IDLE   | waiting for start; x/y/z/i loaded on capture
//   S_ITER   | one micro-rotation per enabled cycle, ITERATIONS in total
//   S_SCALE  | magnitude only: x multiplied by the CORDIC gain 0.6073
//   S_FINISH | result registered, done raised for one enabled cycle
module cordic_vectoring_iter #(
  parameter int ITERATIONS = 16,
  parameter int GUARD_BITS = 2
) (
  input  logic        clock,
  input  logic        aclr,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  input  logic        n,
  output logic [31:0] result,
  output logic        done
);

  localparam int W = 21 + GUARD_BITS;
  localparam logic [3:0] I_LAST = 4'(ITERATIONS - 1);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ITER   = 2'd1;
`ifdef CORDIC_MAG_EN
  localparam logic [1:0] S_SCALE  = 2'd2;
`endif
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]          state;
  logic signed [W-1:0] x_q, y_q, z_q;
  logic [3:0]          i_q;
  logic                nan_q, yzero_q;
  logic signed [W-1:0] x_in, y_in, x_sh, y_sh, atan_i, conv_src;
  logic [31:0]         fin_word;
  logic                unused_bits;

  assign unused_bits = ^{dataa[2:0], datab[2:0]};

  // Float sign/exponent/upper-20-mantissa bits to a Q1.20 value at internal width.
  function automatic logic signed [W-1:0] to_fix(input logic [28:0] f);
    logic [20:0]         mag;
    logic signed [W-1:0] v;
    if (f[27:20] == 8'd0)
      mag = '0;
    else if (f[27:20] >= 8'd127)
      mag = 21'h0F_FFFF;
    else
      mag = {1'b1, f[19:0]} >> (8'd127 - f[27:20]);
    v = $signed({{(W-21){1'b0}}, mag});
    return f[28] ? -v : v;
  endfunction

  // Truncating fixed-to-float: leading one sets the exponent, next 23 bits the mantissa.
  function automatic logic [31:0] to_float(input logic signed [W-1:0] v);
    logic [W-1:0]  mag;
    logic [W+22:0] ext;
    logic [22:0]   mant;
    logic [7:0]    expo;
    int            lead;
    mag  = v[W-1] ? -v : v;
    lead = 0;
    for (int b = 0; b < W; b++)
      if (mag[b]) lead = b;
    ext  = {mag, 23'd0} << (W - 1 - lead);
    mant = 23'(ext >> (W - 1));
    expo = 8'(127 + lead - 20);
    if (mag == '0) return 32'h0000_0000;
    return {v[W-1], expo, mant};
  endfunction

  function automatic logic signed [W-1:0] atan_lut(input logic [3:0] idx);
    logic [20:0] a;
    case (idx)
      4'd0:  a = 21'd823550;
      4'd1:  a = 21'd486170;
      4'd2:  a = 21'd256879;
      4'd3:  a = 21'd130396;
      4'd4:  a = 21'd65451;
      4'd5:  a = 21'd32757;
      4'd6:  a = 21'd16383;
      4'd7:  a = 21'd8192;
      4'd8:  a = 21'd4096;
      4'd9:  a = 21'd2048;
      4'd10: a = 21'd1024;
      4'd11: a = 21'd512;
      4'd12: a = 21'd256;
      4'd13: a = 21'd128;
      4'd14: a = 21'd64;
      default: a = 21'd32;
    endcase
    return $signed({{(W-21){1'b0}}, a});
  endfunction

  assign x_in   = to_fix(dataa[31:3]);
  assign y_in   = to_fix(datab[31:3]);
  assign x_sh   = x_q >>> i_q;
  assign y_sh   = y_q >>> i_q;
  assign atan_i = atan_lut(i_q);

`ifdef CORDIC_MAG_EN
  localparam logic signed [20:0] GAIN = 21'b010011011011101001110;
  logic                  n_q;
  logic signed [W+20:0]  scale_prod;

  assign scale_prod = x_q * GAIN;
  assign conv_src   = n_q ? x_q : z_q;

  // A zero Y only forces a zero angle; the magnitude of (X, 0) is still |X|.
  always_comb begin
    fin_word = to_float(conv_src);
    if (nan_q)
      fin_word = QNAN;
    else if (yzero_q && !n_q)
      fin_word = 32'h0000_0000;
  end
`else
  logic unused_n;
  assign unused_n = n;
  assign conv_src = z_q;

  always_comb begin
    fin_word = to_float(conv_src);
    if (nan_q)
      fin_word = QNAN;
    else if (yzero_q)
      fin_word = 32'h0000_0000;
  end
`endif

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state   <= S_IDLE;
      result  <= '0;
      done    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      nan_q   <= 1'b0;
      yzero_q <= 1'b0;
`ifdef CORDIC_MAG_EN
      n_q     <= 1'b0;
`endif
    end else if (clk_en) begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            x_q     <= x_in;
            y_q     <= y_in;
            z_q     <= '0;
            i_q     <= '0;
            nan_q   <= dataa[31] | (x_in == '0);
            yzero_q <= (y_in == '0);
`ifdef CORDIC_MAG_EN
            n_q     <= n;
`endif
            state   <= S_ITER;
          end
        end
        S_ITER: begin
          // Both updates read the pre-rotation x/y.
          if (!y_q[W-1]) begin
            x_q <= x_q + y_sh;
            y_q <= y_q - x_sh;
            z_q <= z_q + atan_i;
          end else begin
            x_q <= x_q - y_sh;
            y_q <= y_q + x_sh;
            z_q <= z_q - atan_i;
          end
          if (i_q == I_LAST) begin
`ifdef CORDIC_MAG_EN
            state <= n_q ? S_SCALE : S_FINISH;
`else
            state <= S_FINISH;
`endif
          end else begin
            i_q <= i_q + 4'd1;
          end
        end
`ifdef CORDIC_MAG_EN
        S_SCALE: begin
          x_q   <= W'(scale_prod >>> 20);
          state <= S_FINISH;
        end
`endif
        S_FINISH: begin
          result <= fin_word;
          done   <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vectoring_iter.sv
// Directed scoreboard bench for cordic_vectoring_iter: angle accuracy, domain cases,
// latency, start-while-busy, mid-operation reset and clk_en stalls.
module tb_cordic_vectoring_iter;

  logic        clock = 1'b0;
  logic        aclr, clk_en, start, n, done;
  logic [31:0] dataa, datab, result;

  int n_checks = 0;
  int n_errors = 0;

  string       sb_tag[$];
  bit          sb_exact[$];
  logic [31:0] sb_bits[$];
  real         sb_val[$];
  real         sb_tol[$];
  int          sb_lat[$];

  localparam real TOL14 = 1.0 / 16384.0;
  localparam real TOL13 = 1.0 / 8192.0;

  cordic_vectoring_iter dut (
    .clock  (clock),
    .aclr   (aclr),
    .clk_en (clk_en),
    .start  (start),
    .dataa  (dataa),
    .datab  (datab),
    .n      (n),
    .result (result),
    .done   (done)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic real f2r(input logic [31:0] b);
    real r;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    if (b[30:23] == 8'hFF) return 1.0e30;
    r = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return b[31] ? -r : r;
  endfunction

  task automatic check_bits(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_close(input string tag, input logic [31:0] obs, input real exp, input real tol);
    real v;
    bit  ok;
    v  = f2r(obs);
    ok = ((v - exp) < tol) && ((exp - v) < tol);
    n_checks++;
    assert (ok === 1'b1) else begin
      n_errors++;
      $error("FAIL %s: observed %h (%f) expected %f within %f", tag, obs, v, exp, tol);
    end
  endtask

  task automatic push(input string tag, input bit exact, input logic [31:0] bits,
                      input real val, input real tol, input int lat);
    sb_tag.push_back(tag);
    sb_exact.push_back(exact);
    sb_bits.push_back(bits);
    sb_val.push_back(val);
    sb_tol.push_back(tol);
    sb_lat.push_back(lat);
  endtask

  // Called 1 time unit after an edge; start is sampled at the next edge.
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic nsel);
    dataa = x;
    datab = y;
    n     = nsel;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int already);
    int          cnt;
    string       tag;
    bit          exact;
    logic [31:0] bits;
    real         val, tol;
    int          lat;
    cnt = already;
    while (done !== 1'b1 && cnt < 80) begin
      @(posedge clock); #1;
      cnt++;
    end
    tag   = sb_tag.pop_front();
    exact = sb_exact.pop_front();
    bits  = sb_bits.pop_front();
    val   = sb_val.pop_front();
    tol   = sb_tol.pop_front();
    lat   = sb_lat.pop_front();
    check_bits({tag, " done seen"}, {31'd0, done}, 32'd1);
    check_int({tag, " latency"}, cnt, lat);
    if (exact)
      check_bits({tag, " result"}, result, bits);
    else begin
      check_close({tag, " result"}, result, val, tol);
      check_bits({tag, " sign"}, {31'd0, result[31]}, {31'd0, (val < 0.0)});
    end
    @(posedge clock); #1;
    check_bits({tag, " done pulse width"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int pulses;
    aclr   = 1'b1;
    clk_en = 1'b1;
    start  = 1'b0;
    n      = 1'b0;
    dataa  = '0;
    datab  = '0;
    #12;
    check_bits("reset result", result, 32'h0);
    check_bits("reset done", {31'd0, done}, 32'd0);
    @(posedge clock); #1;
    aclr = 1'b0;
    @(posedge clock); #1;

    push("pi/4", 1'b0, '0, 0.785398, TOL14, 17);
    issue(32'h3F00_0000, 32'h3F00_0000, 1'b0);
    wait_done(0);

    push("atan(-0.5)", 1'b0, '0, -0.463648, TOL14, 17);
    issue(32'h3F00_0000, 32'hBE80_0000, 1'b0);
    wait_done(0);

    push("y zero", 1'b1, 32'h0000_0000, 0.0, 0.0, 17);
    issue(32'h3F00_0000, 32'h0000_0000, 1'b0);
    wait_done(0);

    push("x negative", 1'b1, 32'h7FC0_0000, 0.0, 0.0, 17);
    issue(32'hBF00_0000, 32'h3F00_0000, 1'b0);
    wait_done(0);

    push("x zero", 1'b1, 32'h7FC0_0000, 0.0, 0.0, 17);
    issue(32'h0000_0000, 32'h3F00_0000, 1'b0);
    wait_done(0);

    push("saturated 1,1", 1'b0, '0, 0.785398, TOL14, 17);
    issue(32'h3F80_0000, 32'h3F80_0000, 1'b0);
    wait_done(0);

    push("saturated x=2", 1'b0, '0, 0.463648, TOL14, 17);
    issue(32'h4000_0000, 32'h3F00_0000, 1'b0);
    wait_done(0);

    push("y underflow", 1'b1, 32'h0000_0000, 0.0, 0.0, 17);
    issue(32'h3F00_0000, 32'h3080_0000, 1'b0);
    wait_done(0);

    push("steep negative", 1'b0, '0, -1.299849, TOL14, 17);
    issue(32'h3E80_0000, 32'hBF66_6666, 1'b0);
    wait_done(0);

    // Restarts at cycles 3 and 10 of a busy operation must be ignored.
    push("restart ignored", 1'b0, '0, -0.463648, TOL14, 17);
    issue(32'h3F00_0000, 32'hBE80_0000, 1'b0);
    repeat (2) begin @(posedge clock); #1; end
    issue(32'h3F00_0000, 32'h3F00_0000, 1'b0);
    repeat (6) begin @(posedge clock); #1; end
    issue(32'h3F00_0000, 32'h3F00_0000, 1'b0);
    wait_done(10);

    // Reset at cycle 8 abandons the operation.
    issue(32'h3F00_0000, 32'h3F00_0000, 1'b0);
    repeat (7) begin @(posedge clock); #1; end
    aclr = 1'b1;
    #1;
    check_bits("mid-op reset result", result, 32'h0);
    check_bits("mid-op reset done", {31'd0, done}, 32'd0);
    @(posedge clock); #1;
    aclr = 1'b0;
    pulses = 0;
    repeat (25) begin
      @(posedge clock); #1;
      if (done === 1'b1) pulses++;
    end
    check_int("no done after reset", pulses, 0);

    push("after reset", 1'b0, '0, 0.785398, TOL14, 17);
    issue(32'h3F00_0000, 32'h3F00_0000, 1'b0);
    wait_done(0);

    // Five clk_en-low cycles mid-ITER stretch latency to 22.
    push("stalled", 1'b0, '0, -0.463648, TOL14, 22);
    issue(32'h3F00_0000, 32'hBE80_0000, 1'b0);
    repeat (4) begin @(posedge clock); #1; end
    clk_en = 1'b0;
    repeat (5) begin @(posedge clock); #1; end
    clk_en = 1'b1;
    wait_done(9);

`ifdef CORDIC_MAG_EN
    push("magnitude", 1'b0, '0, 1.0, TOL13, 18);
    issue(32'h3F19_999A, 32'h3F4C_CCCD, 1'b1);
    wait_done(0);

    push("mag build angle", 1'b0, '0, 0.927295, TOL14, 17);
    issue(32'h3F19_999A, 32'h3F4C_CCCD, 1'b0);
    wait_done(0);

    push("magnitude x negative", 1'b1, 32'h7FC0_0000, 0.0, 0.0, 18);
    issue(32'hBF00_0000, 32'h3F00_0000, 1'b1);
    wait_done(0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cordic_vectoring_iter.md
Name: cordic_vectoring_iter

Overview:
- Iterative vectoring-mode CORDIC: the inverse of the cosine rotation pipeline. Takes a vector (X, Y) and rotates it onto the x-axis to recover the angle atan(Y/X); optionally also returns the vector magnitude.
- Attached to the Nios II as a multi-cycle custom instruction with start/done handshake.
- Reuses the team's float<->Q1.20 conventions: 21-bit signed, 20 fraction bits, gain constant 0.6073 = 21'b010011011011101001110.
- One shared iteration datapath; area over throughput.

Parameters:
- ITERATIONS, 16, number of micro-rotations, legal range 1..16. Uses the atan(2^-i) Q1.20 table entries for i = 0..15.
- GUARD_BITS, 2, extra integer bits on the internal x/y/z registers. Internal width = 21+GUARD_BITS, which holds pi/2 and a gain-expanded magnitude without overflow.

Ports:
- clock  in  1  rising-edge clock
- aclr  in  1  asynchronous active-high reset
- clk_en  in  1  global enable. Low freezes all state and outputs.
- start  in  1  custom-instruction start, sampled when clk_en=1
- dataa  in  32  X, IEEE-754 single precision
- datab  in  32  Y, IEEE-754 single precision
- n  in  1  result select; meaningful only with CORDIC_MAG_EN
- result  out  32  IEEE-754 single-precision result
- done  out  1  one-cycle completion pulse; result is valid in the same cycle

Behaviour:
- Reset (async on aclr, any state): state=IDLE; result=0; done=0; x/y/z/iteration counter cleared. Reset mid-operation abandons the operation with no done pulse.
- Input conversion, applied on capture:
  - exponent==0 -> 0.
  - exponent>=127 (|v|>=1) -> saturate to ±(2^20-1).
  - Otherwise {1,mant[22:3]}>>(127-exp), negated if sign=1. Sign-extended to internal width.
- FSM:
  - IDLE: on start&clk_en, latch x=X, y=Y, z=0, i=0; go to ITER.
  - ITER: one micro-rotation per enabled cycle.
    - If y>=0: x+=y>>>i; y-=x>>>i; z+=atan_i.
    - Else: x-=y>>>i; y+=x>>>i; z-=atan_i.
    - All three updates use the pre-update x/y. Shifts are arithmetic.
    - After ITERATIONS updates, go to FINISH.
  - FINISH: register result, done=1 for exactly one enabled cycle; return to IDLE.
- Latency: start sampled at edge k -> done=1 after edge k+ITERATIONS+1 (17 cycles for default), with clk_en held high. Each clk_en-low cycle adds one cycle of latency.
- start while not IDLE: ignored. No queueing, no restart.
- start in the FINISH cycle: ignored. A new operation is accepted from the next IDLE cycle.
- Domain (X>0 required):
  - X sign=1 or X converts to 0 -> result=0x7FC00000 (quiet NaN). Latency unchanged; iterations still run.
  - Y converts to 0 (X valid) -> result=0x00000000.
- Output conversion:
  - Take the magnitude of z.
  - Leading-one search over the internal width; exponent = 127 + (lead_pos - 20); mantissa = next 23 bits below the leading one, zero-filled, truncated (no rounding).
  - Sign bit = z sign. Zero magnitude -> 0x00000000.
- Accuracy: |angle error| < 2^-14 rad for ITERATIONS=16.
- done stays low in all states other than FINISH. result holds its value until the next FINISH.

Optional Feature:
- Macro CORDIC_MAG_EN.
- Defined:
  - n=1 selects magnitude: final x multiplied by 0.6073 (Q1.20 constant, one internal-width x 21 multiply, truncated to Q1.20-aligned internal width), then float-converted.
  - Adds one cycle: FINISH is preceded by a SCALE state when n=1. Magnitude latency = ITERATIONS+2.
  - n is latched at start. n=0 behaves as the angle path.
  - X<=0 with n=1 still returns 0x7FC00000.
- Undefined: n ignored; SCALE state and multiplier absent; result is always the angle.

Test Plan:
- X=0x3F000000 (0.5), Y=0x3F000000 -> done exactly 17 cycles after start; result ≈ 0x3F490FDB (0.785398) within 2^-14.
- X=0x3F000000, Y=0xBE800000 (-0.25) -> result ≈ 0xBEED6338 (-0.463648) within 2^-14; sign bit set.
- Y=0x00000000, X=0x3F000000 -> 0x00000000. X=0xBF000000 (-0.5), Y=0.5 -> 0x7FC00000, still 17-cycle latency.
- Handshake/reset:
  - start pulsed again at cycles 3 and 10 of a busy operation -> single done pulse, first operation's result.
  - aclr asserted at cycle 8 -> result=0, done=0 immediately, no done pulse; a subsequent start completes normally.
- clk_en held low for 5 cycles mid-ITER -> done after 22 cycles; result identical to the unstalled run.
- With CORDIC_MAG_EN: X=0x3F19999A (0.6), Y=0x3F4CCCCD (0.8), n=1 -> result ≈ 0x3F800000 (1.0) within 2^-13, latency 18. Same inputs with n=0 -> ≈ 0x3F6D6338 (0.927295).
